// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and default sizes for the pattern scan controller and its detector.
package pattern_scan_ctrl_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned PAT_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/pattern_moore_det.sv
// Bit-serial Moore pattern detector: history shift register, fill counter, registered hit.
module pattern_moore_det #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              hit_q, hit_d;

  // Oldest bit sits in the MSB so pattern[PAT_W-1] is compared against the earliest bit.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    hit_d  = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = {hist_q[PAT_W-2:0], bit_in};
      if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      hit_d = (fill_q >= FILL_W'(PAT_W - 1)) && (hist_d == pattern);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Schedules one word-scan job onto the serial detector and accumulates match count/position.
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned PAT_W  = PAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              first_valid,
  output logic              ser_bit,
  output logic              hit
);

  scan_state_e       state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              ser_bit_q, ser_bit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  first_pos_q, first_pos_d;
  logic              first_valid_q, first_valid_d;
  logic              det_clr_c;
  logic              det_hit;

  // word_q holds the not-yet-presented bits left-aligned; ser_bit_q is the bit at the detector.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    pat_d         = pat_q;
    idx_d         = idx_q;
    ser_bit_d     = 1'b0;
    match_cnt_d   = match_cnt_q;
    first_pos_d   = first_pos_q;
    first_valid_d = first_valid_q;
    det_clr_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          det_clr_c     = 1'b1;
          word_d        = {data_in[WORD_W-2:0], 1'b0};
          pat_d         = pattern;
          ser_bit_d     = data_in[WORD_W-1];
          idx_d         = '0;
          match_cnt_d   = '0;
          first_pos_d   = '0;
          first_valid_d = 1'b0;
          state_d       = S_SHIFT;
        end
      end
      S_SHIFT: begin
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == CNT_W'(WORD_W - 1)) begin
          state_d = S_DRAIN;
        end else begin
          ser_bit_d = word_q[WORD_W-1];
          word_d    = {word_q[WORD_W-2:0], 1'b0};
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A hit seen now belongs to the bit presented one cycle earlier (index idx_q-1).
    if (det_hit && (state_q == S_SHIFT || state_q == S_DRAIN)) begin
      if (match_cnt_q != '1) begin
        match_cnt_d = match_cnt_q + CNT_W'(1);
      end
      if (!first_valid_q) begin
        first_valid_d = 1'b1;
        first_pos_d   = (state_q == S_DRAIN) ? CNT_W'(WORD_W - 1) : (idx_q - CNT_W'(1));
      end
    end
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      pat_q         <= '0;
      idx_q         <= '0;
      ser_bit_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      match_cnt_q   <= '0;
      first_pos_q   <= '0;
      first_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      pat_q         <= pat_d;
      idx_q         <= idx_d;
      ser_bit_q     <= ser_bit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      match_cnt_q   <= match_cnt_d;
      first_pos_q   <= first_pos_d;
      first_valid_q <= first_valid_d;
    end
  end

  pattern_moore_det #(
    .PAT_W(PAT_W)
  ) u_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (det_clr_c),
    .bit_valid(state_q == S_SHIFT),
    .bit_in   (ser_bit_q),
    .pattern  (pat_q),
    .hit      (det_hit)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign match_cnt   = match_cnt_q;
  assign first_pos   = first_pos_q;
  assign first_valid = first_valid_q;
  assign ser_bit     = ser_bit_q;
  assign hit         = det_hit;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl against a string-search reference model.
module tb_pattern_scan_ctrl;

  localparam int W  = 32;
  localparam int P  = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  data_in;
  logic [P-1:0]  pattern;
  logic          busy, done, first_valid, ser_bit, hit;
  logic [CW-1:0] match_cnt, first_pos;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_cnt;
  int exp_pos;
  int exp_valid;
  bit exp_hit [W];

  pattern_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .pattern    (pattern),
    .busy       (busy),
    .done       (done),
    .match_cnt  (match_cnt),
    .first_pos  (first_pos),
    .first_valid(first_valid),
    .ser_bit    (ser_bit),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scan the word MSB-first as a bit sequence and look for every window equal to the pattern.
  task automatic model(input logic [W-1:0] d, input logic [P-1:0] p);
    bit seq [W];
    exp_cnt = 0; exp_pos = 0; exp_valid = 0;
    for (int k = 0; k < W; k++) begin
      seq[k] = d[W-1-k];
      exp_hit[k] = 1'b0;
    end
    for (int k = P - 1; k < W; k++) begin
      bit m = 1'b1;
      for (int j = 0; j < P; j++)
        if (seq[k-P+1+j] != p[P-1-j]) m = 1'b0;
      if (m) begin
        exp_hit[k] = 1'b1;
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        if (exp_valid == 0) begin
          exp_valid = 1;
          exp_pos   = k;
        end
      end
    end
  endtask

  // Runs one job; restart_at>0 pulses start in that cycle of the job (must be ignored).
  task automatic run_job(input logic [W-1:0] d, input logic [P-1:0] p, input int restart_at);
    int cyc;
    int done_cyc;
    model(d, p);
    @(negedge clk);
    start = 1'b1; data_in = d; pattern = p;
    @(posedge clk); #1;
    start = 1'b0; data_in = $urandom; pattern = P'($urandom);
    cyc = 1; done_cyc = -1;
    while (cyc < 60 && done_cyc < 0) begin
      start = (cyc == restart_at);
      if (start) begin
        data_in = $urandom; pattern = P'($urandom);
      end
      check("busy", 32'(busy), 1);
      if (cyc <= W) check("ser_bit", 32'(ser_bit), 32'(d[W-cyc]));
      if (cyc >= 2 && cyc <= W + 1) check("hit", 32'(hit), 32'(exp_hit[cyc-2]));
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(W + 2));
    check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
    check("first_pos", 32'(first_pos), 32'(exp_pos));
    check("first_valid", 32'(first_valid), 32'(exp_valid));
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 0);
    check("busy_after", 32'(busy), 0);
    check("cnt_hold", 32'(match_cnt), 32'(exp_cnt));
    check("pos_hold", 32'(first_pos), 32'(exp_pos));
  endtask

  initial begin
    logic [W-1:0] w;
    logic [P-1:0] pt;
    reset = 1'b0; start = 1'b0; data_in = '0; pattern = '0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_pos", 32'(first_pos), 0);
    check("rst_valid", 32'(first_valid), 0);
    check("rst_ser", 32'(ser_bit), 0);
    check("rst_hit", 32'(hit), 0);
    @(negedge clk); reset = 1'b1;

    run_job(32'b01011011011001101101100101101100, 5'b11011, 0);
    check("t1_cnt", 32'(match_cnt), 5);
    check("t1_pos", 32'(first_pos), 7);
    run_job(32'hFFFFFFFF, 5'b11111, 0);
    check("t2_cnt", 32'(match_cnt), 28);
    check("t2_pos", 32'(first_pos), 4);
    run_job(32'h00000000, 5'b11011, 0);
    check("t3_valid", 32'(first_valid), 0);
    run_job(32'b01011011011001101101100101101100, 5'b11011, 10);
    check("t4_cnt", 32'(match_cnt), 5);
    run_job(32'h00000003, 5'b11011, 0);
    run_job(32'h60000000, 5'b11011, 0);
    check("b2b_cnt", 32'(match_cnt), 0);

    // Reset in cycle 15 of a job aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; data_in = 32'b01011011011001101101100101101100; pattern = 5'b11011;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_cnt", 32'(match_cnt), 0);
    check("mid_rst_valid", 32'(first_valid), 0);
    check("mid_rst_hit", 32'(hit), 0);
    @(negedge clk); reset = 1'b1;
    run_job(32'b01011011011001101101100101101100, 5'b11011, 0);
    check("after_rst_cnt", 32'(match_cnt), 5);

    for (int i = 0; i < 24; i++) begin
      pt = P'($urandom_range(0, (1 << P) - 1));
      case (i % 3)
        0: w = $urandom;
        1: w = $urandom | $urandom;
        default: w = W'({7{pt}} >> $urandom_range(0, 3));
      endcase
      run_job(w, pt, (i % 4 == 0) ? $urandom_range(1, W + 2) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Controller that schedules one word-scan job onto a shared serial pattern detector. It accepts a parallel data word and a programmable pattern through a start handshake. It then feeds the word MSB-first into the detector one bit per clock, counts overlapping Moore-style matches and reports the match count and the first match position. It sits between a register/host interface and the bit-serial detector datapath, and owns that detector's sequencing and clearing.

## Interface
- WORD_W, 32, data word width (bits scanned per job), ≥ PAT_W
- PAT_W, 5, pattern length in bits, 2..8
- CNT_W, 6, width of count/position outputs; must hold WORD_W
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  job request, sampled only in IDLE
- data_in  in  WORD_W  word to scan, captured on accepted start
- pattern  in  PAT_W  pattern, captured on accepted start; pattern[PAT_W-1] is matched first in time
- busy  out  1  high from the cycle after start acceptance through DONE
- done  out  1  single-cycle pulse; results valid in that cycle and held until next accept
- match_cnt  out  CNT_W  number of overlapping matches in the word
- first_pos  out  CNT_W  bit index (0 = MSB) of the last bit of the first match
- first_valid  out  1  at least one match found
- ser_bit  out  1  bit currently presented to the detector (debug)
- hit  out  1  registered detector output (debug)

## Operation
- Reset values: state IDLE; busy, done, hit, ser_bit, first_valid at 0; match_cnt and first_pos at 0; detector history and fill count cleared.
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - start=1 captures data_in and pattern, clears the detector and clears all results.
  - Moves to SHIFT with bit index 0.
- SHIFT:
  - Presents data[WORD_W-1-idx] to the detector and increments idx.
  - After idx = WORD_W-1, moves to DRAIN.
- DRAIN: one cycle to collect the hit from the final bit, then moves to DONE.
- DONE: done=1 for one cycle, then moves to IDLE.
- start outside IDLE is ignored. It is not queued.
- Detector (Moore behaviour):
  - Keeps a PAT_W-bit history shift register and a fill counter.
  - hit is registered high for the bit index k when fill ≥ PAT_W and history equals pattern.
  - Matches overlap, so the history is not cleared on a hit.
  - The detector is cleared at every accepted start, so no match spans two words.
- Counting:
  - Each cycle with hit=1 increments match_cnt. match_cnt saturates at 2^CNT_W-1.
  - On the first hit, first_pos is set to k and first_valid is set to 1.
- reset asserted mid-job: immediate return to reset values. A partial result is never reported and done is not pulsed.

## Timing
- Cycle 0: start accepted.
- Cycles 1..WORD_W: SHIFT, presenting bit index k in cycle k+1.
- The hit for bit k is visible in cycle k+2 (one cycle of Moore latency). It is counted at the end of that cycle.
- Cycle WORD_W+1: DRAIN. Cycle WORD_W+2: DONE, with done=1.
- With defaults, done is high in cycle 34 and the next start can be accepted in cycle 35.
- Results change only at the edge that ends the start-accept cycle (cleared) and during scanning. They are stable from DONE until the next accept.

## Structure
- Shared package: state encoding constants (IDLE/SHIFT/DRAIN/DONE), default WORD_W/PAT_W/CNT_W.
- Sub-module: pattern_moore_det, containing the history register, fill counter, compare and registered hit. It has a synchronous clear input driven by the controller.
- The controller holds the FSM, the captured word, the bit index counter and the result registers.

## Test plan
- data_in=32'b01011011011001101101100101101100, pattern=5'b11011 -> match_cnt=5, first_pos=7, first_valid=1, done in cycle 34.
- data_in=32'hFFFFFFFF, pattern=5'b11111 -> match_cnt=28, first_pos=4.
- data_in=32'h00000000, pattern=5'b11011 -> match_cnt=0, first_valid=0, first_pos=0.
- start pulsed again in cycle 10 of a job -> ignored; the result equals the single-job result and busy stays high continuously.
- Back-to-back jobs:
  - Word A = 32'h00000003 (ends in ...11), pattern 11011 -> count 0.
  - Then word B = 32'h60000000 (starts 011) -> count 0, confirming no cross-word match.
- reset driven to 0 in cycle 15 of the test-1 job -> busy/done/match_cnt go to 0 immediately. A new job after release gives count 5.
